apb: RTL and testbench
======================

Name: apb

Overview:
- APB-style configuration register bank for the DFE filter array.
- Driven by a simple master-side request (MTRANS/MWRITE/MSELx/MADDR/MWDATA) and run internally as two-phase APB transfers (SETUP, ACCESS).
- Holds fractional-decimator, IIR and CIC coefficients, control, output select and status bits, and drives them to the filter chain.
- Read data is returned on MRDATA.

Parameters:
ADDR_WIDTH, 7, register address width
PDATA_WIDTH, 32, read data width
COEFF_WIDTH, 20, coefficient / write data width (signed)
N_TAP, 72, fractional-decimator coefficient count
NUM_DENUM, 5, coefficients per IIR stage
COMP, 5, number of component select lines

Ports:
clk  in  1  system clock (all flops on rising edge)
rst_n  in  1  asynchronous active-low reset
MTRANS  in  1  transfer request, sampled on rising clk
MWRITE  in  1  1=write, 0=read
MSELx  in  COMP  component select: bit0 frac-deci, bit1 IIR, bit2 CIC, bit3 control, bit4 FIR
MADDR  in  ADDR_WIDTH  register address
MWDATA  in  COEFF_WIDTH  signed write data
MRDATA  out  PDATA_WIDTH  read data
FRAC_DECI_VLD  out  1  frac-deci coefficient set complete pulse
FRAC_DECI_OUT  out  N_TAP x COEFF_WIDTH  frac-deci coefficients
IIR_24_VLD / IIR_5_1_VLD / IIR_5_2_VLD  out  1 each  coefficient set complete pulses
IIR_24_OUT / IIR_5_1_OUT / IIR_5_2_OUT  out  NUM_DENUM x COEFF_WIDTH each  IIR coefficients
CTRL_OUT  out  5 x 1  stage enables
CIC_R_VLD  out  1  CIC ratio written pulse
CIC_R_OUT  out  5  CIC decimation ratio
OUT_SEL  out  2  output mux select
FRAC_DECI_STATUS, IIR_24_STATUS, IIR_5_1_STATUS, IIR_5_2_STATUS, CIC_STATUS, FIR_STATUS  out  2 x 1 each  [0]=overflow, [1]=underflow flags

Behaviour:
- Address map (N_TAP=72, NUM_DENUM=5), with required MSELx bit per range:
  - 0..71 FRAC_DECI_OUT[a], bit0.
  - 72..76 IIR_24_OUT[a-72], bit1.
  - 77..81 IIR_5_1_OUT, bit1.
  - 82..86 IIR_5_2_OUT, bit1.
  - 87 CIC_R_OUT = MWDATA[4:0], bit2.
  - 88..92 CTRL_OUT[a-88] = MWDATA[0], bit3.
  - 93 OUT_SEL = MWDATA[1:0], bit3.
  - 94/95 FRAC_DECI_STATUS[0]/[1], bit0.
  - 96/97 IIR_24_STATUS, bit1.
  - 98/99 IIR_5_1_STATUS, bit1.
  - 100/101 IIR_5_2_STATUS, bit1.
  - 102/103 CIC_STATUS, bit2.
  - 104/105 FIR_STATUS, bit4.
  - Status bits take MWDATA[0].
- All range bounds derive from the parameters.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: if MTRANS=1, capture MWRITE/MSELx/MADDR/MWDATA into a request register and go to SETUP; else stay.
  - SETUP: always go to ACCESS (PENABLE phase).
  - ACCESS: commit the captured request. Then, if MTRANS=1, capture a new request and go to SETUP (back-to-back, 2 cycles per transfer); else go to IDLE.
- Inputs are used only via the captured copy; changes during SETUP/ACCESS do not affect the current transfer.
- Write commit (ACCESS edge): update the addressed register only if the captured MSELx has the region's bit set. Otherwise, or for an unmapped address (106..127), no register changes.
- Read commit (ACCESS edge): MRDATA <= addressed register. Coefficients are sign-extended to PDATA_WIDTH; bit registers are zero-extended. Mismatched select or unmapped address returns 0. MRDATA holds its value until the next read commit; writes do not change it.
- VLD pulses are one clk high, on the cycle after the commit of a write to the last address of the set:
  - FRAC_DECI_VLD after addr N_TAP-1.
  - IIR_24_VLD after 76; IIR_5_1_VLD after 81; IIR_5_2_VLD after 86.
  - CIC_R_VLD after addr 87.
  - Any other cycle: 0.
- Register outputs are continuously driven from storage; a new value is visible the cycle after commit.
- Reset (async, rst_n=0): FSM to IDLE; all coefficients, CTRL_OUT, CIC_R_OUT, OUT_SEL, status bits, MRDATA and VLDs cleared to 0. Reset mid-transfer aborts it with no register update.

Test Plan:
- Reset: rst_n low 1 cycle -> every output 0, FSM IDLE.
- Write 72 frac-deci coeffs (SELx=1, addr 0..71, data e.g. -3 at addr 71), MTRANS 2-cycle pulses back-to-back -> FRAC_DECI_OUT[71]=-3; FRAC_DECI_VLD single pulse after addr 71 only.
- Write IIR sets (SELx=2, addr 72..86) -> each *_OUT holds data; three VLD pulses after addrs 76, 81, 86. Write addr 87 SELx=4 data 0x14 -> CIC_R_OUT=5'h14, CIC_R_VLD pulse.
- Read addr 71 SELx=1 after writing -3 -> MRDATA=32'hFFFFFFFD (sign-extended). Read addr 81 with SELx=1 (mismatch) -> MRDATA=0.
- Write addrs 88..92 (SELx=8, odd data) -> CTRL_OUT all 1. Addr 93 data 2 -> OUT_SEL=2. Addrs 94..105 with matching SELx, data bit0=1 -> all status bits 1. Addr 104 with SELx=1 -> FIR_STATUS unchanged.
- Assert rst_n low during SETUP of a write to addr 5 -> FRAC_DECI_OUT[5] stays 0, FSM IDLE.

Source files
------------

// File: rtl/apb.sv
// apb: APB-style configuration register bank for the DFE filter array.
//
// A master-side request (MTRANS/MWRITE/MSELx/MADDR/MWDATA) is captured and
// run as a two-phase transfer (SETUP, ACCESS). The captured request is
// committed on the ACCESS clock edge. Back-to-back requests take two cycles each.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   MTRANS                transfer request
//   MWRITE                1 = write, 0 = read
//   MSELx[COMP]           component select (0 frac-deci, 1 IIR, 2 CIC, 3 control, 4 FIR)
//   MADDR[ADDR_WIDTH]     register address
//   MWDATA[COEFF_WIDTH]   signed write data
//   MRDATA[PDATA_WIDTH]   read data (held until the next read commit)
//   *_VLD                 one-cycle pulse after the last coefficient of a set is written
//   *_OUT                 coefficient / control storage driven to the filter chain
//   *_STATUS[1:0]         [0] overflow, [1] underflow flags
module apb #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned PDATA_WIDTH = 32,
    parameter int unsigned COEFF_WIDTH = 20,
    parameter int unsigned N_TAP       = 72,
    parameter int unsigned NUM_DENUM   = 5,
    parameter int unsigned COMP        = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  MTRANS,
    input  logic                                  MWRITE,
    input  logic [COMP-1:0]                       MSELx,
    input  logic [ADDR_WIDTH-1:0]                 MADDR,
    input  logic [COEFF_WIDTH-1:0]                MWDATA,
    output logic [PDATA_WIDTH-1:0]                MRDATA,
    output logic                                  FRAC_DECI_VLD,
    output logic [N_TAP-1:0][COEFF_WIDTH-1:0]     FRAC_DECI_OUT,
    output logic                                  IIR_24_VLD,
    output logic                                  IIR_5_1_VLD,
    output logic                                  IIR_5_2_VLD,
    output logic [NUM_DENUM-1:0][COEFF_WIDTH-1:0] IIR_24_OUT,
    output logic [NUM_DENUM-1:0][COEFF_WIDTH-1:0] IIR_5_1_OUT,
    output logic [NUM_DENUM-1:0][COEFF_WIDTH-1:0] IIR_5_2_OUT,
    output logic [4:0]                            CTRL_OUT,
    output logic                                  CIC_R_VLD,
    output logic [4:0]                            CIC_R_OUT,
    output logic [1:0]                            OUT_SEL,
    output logic [1:0]                            FRAC_DECI_STATUS,
    output logic [1:0]                            IIR_24_STATUS,
    output logic [1:0]                            IIR_5_1_STATUS,
    output logic [1:0]                            IIR_5_2_STATUS,
    output logic [1:0]                            CIC_STATUS,
    output logic [1:0]                            FIR_STATUS
);

    // Address map, derived from the coefficient counts.
    localparam int unsigned IIR24_BASE = N_TAP;
    localparam int unsigned IIR51_BASE = N_TAP + NUM_DENUM;
    localparam int unsigned IIR52_BASE = N_TAP + 2 * NUM_DENUM;
    localparam int unsigned CIC_ADDR   = N_TAP + 3 * NUM_DENUM;
    localparam int unsigned N_CTRL     = 5;
    localparam int unsigned CTRL_BASE  = CIC_ADDR + 1;
    localparam int unsigned OSEL_ADDR  = CTRL_BASE + N_CTRL;
    localparam int unsigned STAT_BASE  = OSEL_ADDR + 1;
    localparam int unsigned N_STAT     = 6;
    localparam int unsigned STAT_END   = STAT_BASE + 2 * N_STAT;

    localparam int unsigned FD_IW  = (N_TAP > 1) ? $clog2(N_TAP) : 1;
    localparam int unsigned IIR_IW = (NUM_DENUM > 1) ? $clog2(NUM_DENUM) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef enum logic [3:0] {
        R_NONE, R_FD, R_IIR24, R_IIR51, R_IIR52, R_CIC, R_CTRL, R_OSEL, R_STAT
    } region_t;

    state_t state, state_nxt;

    logic                   req_write;
    logic [COMP-1:0]        req_sel;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [COEFF_WIDTH-1:0] req_data;

    // Status flags, index order: frac-deci, IIR24, IIR5_1, IIR5_2, CIC, FIR.
    logic [N_STAT-1:0][1:0] status;

    logic                   capture;
    logic                   commit;
    region_t                region;
    logic                   sel_ok;
    int unsigned            a;
    int unsigned            off;
    logic [FD_IW-1:0]       fd_idx;
    logic [IIR_IW-1:0]      iir_idx;
    logic [2:0]             ctrl_idx;
    logic [2:0]             stat_idx;
    logic                   stat_bit;
    logic                   wr_hit;
    logic [PDATA_WIDTH-1:0] rd_val;

    function automatic logic [PDATA_WIDTH-1:0] sext(input logic [COEFF_WIDTH-1:0] c);
        return {{(PDATA_WIDTH - COEFF_WIDTH){c[COEFF_WIDTH-1]}}, c};
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (MTRANS) begin
                    capture   = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                commit = 1'b1;
                if (MTRANS) begin
                    capture   = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request register: the transfer only ever sees this captured copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_write <= 1'b0;
            req_sel   <= '0;
            req_addr  <= '0;
            req_data  <= '0;
        end else if (capture) begin
            req_write <= MWRITE;
            req_sel   <= MSELx;
            req_addr  <= MADDR;
            req_data  <= MWDATA;
        end
    end

    // ------------------------------------------------------------- decode
    always_comb begin
        a        = 32'(req_addr);
        region   = R_NONE;
        sel_ok   = 1'b0;
        off      = 0;
        if (a < IIR24_BASE) begin
            region = R_FD;    sel_ok = req_sel[0]; off = a;
        end else if (a < IIR51_BASE) begin
            region = R_IIR24; sel_ok = req_sel[1]; off = a - IIR24_BASE;
        end else if (a < IIR52_BASE) begin
            region = R_IIR51; sel_ok = req_sel[1]; off = a - IIR51_BASE;
        end else if (a < CIC_ADDR) begin
            region = R_IIR52; sel_ok = req_sel[1]; off = a - IIR52_BASE;
        end else if (a == CIC_ADDR) begin
            region = R_CIC;   sel_ok = req_sel[2];
        end else if (a < OSEL_ADDR) begin
            region = R_CTRL;  sel_ok = req_sel[3]; off = a - CTRL_BASE;
        end else if (a == OSEL_ADDR) begin
            region = R_OSEL;  sel_ok = req_sel[3];
        end else if (a < STAT_END) begin
            region = R_STAT;  off = a - STAT_BASE;
            case (off >> 1)
                0:       sel_ok = req_sel[0];
                1, 2, 3: sel_ok = req_sel[1];
                4:       sel_ok = req_sel[2];
                default: sel_ok = req_sel[4];
            endcase
        end
        fd_idx   = FD_IW'(off);
        iir_idx  = IIR_IW'(off);
        ctrl_idx = 3'(off);
        stat_idx = 3'(off >> 1);
        stat_bit = off[0];
        wr_hit   = commit && req_write && sel_ok;
    end

    always_comb begin
        rd_val = '0;
        if (sel_ok) begin
            case (region)
                R_FD:    rd_val = sext(FRAC_DECI_OUT[fd_idx]);
                R_IIR24: rd_val = sext(IIR_24_OUT[iir_idx]);
                R_IIR51: rd_val = sext(IIR_5_1_OUT[iir_idx]);
                R_IIR52: rd_val = sext(IIR_5_2_OUT[iir_idx]);
                R_CIC:   rd_val = PDATA_WIDTH'(CIC_R_OUT);
                R_CTRL:  rd_val = PDATA_WIDTH'(CTRL_OUT[ctrl_idx]);
                R_OSEL:  rd_val = PDATA_WIDTH'(OUT_SEL);
                R_STAT:  rd_val = PDATA_WIDTH'(status[stat_idx][stat_bit]);
                default: rd_val = '0;
            endcase
        end
    end

    // ------------------------------------------------------ register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FRAC_DECI_OUT <= '0;
            IIR_24_OUT    <= '0;
            IIR_5_1_OUT   <= '0;
            IIR_5_2_OUT   <= '0;
            CTRL_OUT      <= '0;
            CIC_R_OUT     <= '0;
            OUT_SEL       <= '0;
            status        <= '0;
            MRDATA        <= '0;
            FRAC_DECI_VLD <= 1'b0;
            IIR_24_VLD    <= 1'b0;
            IIR_5_1_VLD   <= 1'b0;
            IIR_5_2_VLD   <= 1'b0;
            CIC_R_VLD     <= 1'b0;
        end else begin
            FRAC_DECI_VLD <= wr_hit && (a == IIR24_BASE - 1);
            IIR_24_VLD    <= wr_hit && (a == IIR51_BASE - 1);
            IIR_5_1_VLD   <= wr_hit && (a == IIR52_BASE - 1);
            IIR_5_2_VLD   <= wr_hit && (a == CIC_ADDR - 1);
            CIC_R_VLD     <= wr_hit && (a == CIC_ADDR);
            if (commit && !req_write) MRDATA <= rd_val;
            if (wr_hit) begin
                case (region)
                    R_FD:    FRAC_DECI_OUT[fd_idx]     <= req_data;
                    R_IIR24: IIR_24_OUT[iir_idx]       <= req_data;
                    R_IIR51: IIR_5_1_OUT[iir_idx]      <= req_data;
                    R_IIR52: IIR_5_2_OUT[iir_idx]      <= req_data;
                    R_CIC:   CIC_R_OUT                 <= req_data[4:0];
                    R_CTRL:  CTRL_OUT[ctrl_idx]        <= req_data[0];
                    R_OSEL:  OUT_SEL                   <= req_data[1:0];
                    R_STAT:  status[stat_idx][stat_bit] <= req_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign FRAC_DECI_STATUS = status[0];
    assign IIR_24_STATUS    = status[1];
    assign IIR_5_1_STATUS   = status[2];
    assign IIR_5_2_STATUS   = status[3];
    assign CIC_STATUS       = status[4];
    assign FIR_STATUS       = status[5];

endmodule

// File: tb/tb_apb.sv
module tb_apb;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 MTRANS = 1'b0;
    logic                 MWRITE = 1'b0;
    logic [4:0]           MSELx = '0;
    logic [6:0]           MADDR = '0;
    logic [19:0]          MWDATA = '0;
    logic [31:0]          MRDATA;
    logic                 FRAC_DECI_VLD, IIR_24_VLD, IIR_5_1_VLD, IIR_5_2_VLD, CIC_R_VLD;
    logic [71:0][19:0]    FRAC_DECI_OUT;
    logic [4:0][19:0]     IIR_24_OUT, IIR_5_1_OUT, IIR_5_2_OUT;
    logic [4:0]           CTRL_OUT, CIC_R_OUT;
    logic [1:0]           OUT_SEL;
    logic [1:0]           FRAC_DECI_STATUS, IIR_24_STATUS, IIR_5_1_STATUS;
    logic [1:0]           IIR_5_2_STATUS, CIC_STATUS, FIR_STATUS;

    int n_total = 0;
    int n_bad   = 0;
    int fd_vld_n = 0, iir24_vld_n = 0, iir51_vld_n = 0, iir52_vld_n = 0, cic_vld_n = 0;

    apb #(
        .ADDR_WIDTH(7), .PDATA_WIDTH(32), .COEFF_WIDTH(20),
        .N_TAP(72), .NUM_DENUM(5), .COMP(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx), .MADDR(MADDR), .MWDATA(MWDATA),
        .MRDATA(MRDATA),
        .FRAC_DECI_VLD(FRAC_DECI_VLD), .FRAC_DECI_OUT(FRAC_DECI_OUT),
        .IIR_24_VLD(IIR_24_VLD), .IIR_5_1_VLD(IIR_5_1_VLD), .IIR_5_2_VLD(IIR_5_2_VLD),
        .IIR_24_OUT(IIR_24_OUT), .IIR_5_1_OUT(IIR_5_1_OUT), .IIR_5_2_OUT(IIR_5_2_OUT),
        .CTRL_OUT(CTRL_OUT), .CIC_R_VLD(CIC_R_VLD), .CIC_R_OUT(CIC_R_OUT), .OUT_SEL(OUT_SEL),
        .FRAC_DECI_STATUS(FRAC_DECI_STATUS), .IIR_24_STATUS(IIR_24_STATUS),
        .IIR_5_1_STATUS(IIR_5_1_STATUS), .IIR_5_2_STATUS(IIR_5_2_STATUS),
        .CIC_STATUS(CIC_STATUS), .FIR_STATUS(FIR_STATUS)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (FRAC_DECI_VLD) fd_vld_n++;
            if (IIR_24_VLD)    iir24_vld_n++;
            if (IIR_5_1_VLD)   iir51_vld_n++;
            if (IIR_5_2_VLD)   iir52_vld_n++;
            if (CIC_R_VLD)     cic_vld_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and walks it to the ACCESS phase; the commit happens
    // on the next edge, either together with the next xfer's capture or via
    // finish_xfer. Inputs are scrambled after capture to prove they are unused.
    task automatic xfer(input logic w, input logic [4:0] sel, input logic [6:0] addr,
                        input logic [19:0] data);
        MTRANS = 1'b1; MWRITE = w; MSELx = sel; MADDR = addr; MWDATA = data;
        @(posedge clk); #1;
        MTRANS = 1'b0; MWRITE = ~w; MSELx = ~sel; MADDR = ~addr; MWDATA = ~data;
        @(posedge clk); #1;
    endtask

    task automatic finish_xfer();
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [4:0] sel, input logic [6:0] addr);
        xfer(1'b0, sel, addr, 20'h0);
        finish_xfer();
    endtask

    logic [19:0] d;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mrdata", MRDATA, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_state", 32'(dut.state), 32'd0);
        check("rst_fd_any", 32'(|FRAC_DECI_OUT), 32'd0);
        check("rst_iir_any", 32'(|{IIR_24_OUT, IIR_5_1_OUT, IIR_5_2_OUT}), 32'd0);
        check("rst_misc", 32'({CTRL_OUT, CIC_R_OUT, OUT_SEL}), 32'd0);
        check("rst_status", 32'({FRAC_DECI_STATUS, IIR_24_STATUS, IIR_5_1_STATUS,
                                 IIR_5_2_STATUS, CIC_STATUS, FIR_STATUS}), 32'd0);
        check("rst_vld", 32'({FRAC_DECI_VLD, IIR_24_VLD, IIR_5_1_VLD, IIR_5_2_VLD, CIC_R_VLD}), 32'd0);

        // Fractional-decimator coefficients, back-to-back
        for (int i = 0; i < 72; i++) begin
            d = (i == 71) ? 20'hFFFFD : 20'(i + 1);
            xfer(1'b1, 5'd1, 7'(i), d);
        end
        finish_xfer();
        check("fd_vld_pulse", 32'(FRAC_DECI_VLD), 32'd1);
        check("fd0", 32'(FRAC_DECI_OUT[0]), 32'd1);
        check("fd35", 32'(FRAC_DECI_OUT[35]), 32'd36);
        check("fd71", 32'(FRAC_DECI_OUT[71]), 32'h000FFFFD);
        @(posedge clk); #1;
        check("fd_vld_low", 32'(FRAC_DECI_VLD), 32'd0);
        check("fd_vld_count", 32'(fd_vld_n), 32'd1);

        // IIR sets plus CIC ratio
        for (int i = 72; i < 87; i++) begin
            d = (i < 82) ? 20'(1000 + i) : 20'(-i);
            xfer(1'b1, 5'd2, 7'(i), d);
        end
        xfer(1'b1, 5'd4, 7'd87, 20'h14);
        finish_xfer();
        check("cic_vld_pulse", 32'(CIC_R_VLD), 32'd1);
        check("iir24_0", 32'(IIR_24_OUT[0]), 32'd1072);
        check("iir24_4", 32'(IIR_24_OUT[4]), 32'd1076);
        check("iir51_4", 32'(IIR_5_1_OUT[4]), 32'd1081);
        check("iir52_2", 32'(IIR_5_2_OUT[2]), 32'h000FFFAC);
        check("cic_r", 32'(CIC_R_OUT), 32'h14);
        @(posedge clk); #1;
        check("iir24_vld_count", 32'(iir24_vld_n), 32'd1);
        check("iir51_vld_count", 32'(iir51_vld_n), 32'd1);
        check("iir52_vld_count", 32'(iir52_vld_n), 32'd1);
        check("cic_vld_count", 32'(cic_vld_n), 32'd1);
        check("fd_vld_count2", 32'(fd_vld_n), 32'd1);

        // Reads, sign extension, select mismatch, unmapped
        rd(5'd1, 7'd71);
        check("rd71", MRDATA, 32'hFFFFFFFD);
        rd(5'd1, 7'd81);
        check("rd81_badsel", MRDATA, 32'h0);
        rd(5'd2, 7'd84);
        check("rd84", MRDATA, 32'hFFFFFFAC);
        xfer(1'b1, 5'd2, 7'd5, 20'd77);
        finish_xfer();
        check("wr5_badsel", 32'(FRAC_DECI_OUT[5]), 32'd6);
        check("mrdata_hold_on_wr", MRDATA, 32'hFFFFFFAC);
        rd(5'd2, 7'd72);
        check("rd72", MRDATA, 32'h430);
        rd(5'h1f, 7'd110);
        check("rd_unmapped", MRDATA, 32'h0);
        rd(5'd4, 7'd87);
        check("rd87", MRDATA, 32'h14);

        // Control, output select, status bits
        for (int i = 0; i < 5; i++) xfer(1'b1, 5'd8, 7'(88 + i), 20'(2 * i + 1));
        xfer(1'b1, 5'd8, 7'd93, 20'd2);
        for (int i = 94; i < 106; i++) begin
            xfer(1'b1, (i < 96) ? 5'd1 : (i < 102) ? 5'd2 : (i < 104) ? 5'd4 : 5'd16,
                 7'(i), 20'd1);
        end
        finish_xfer();
        check("ctrl", 32'(CTRL_OUT), 32'h1f);
        check("out_sel", 32'(OUT_SEL), 32'd2);
        check("status_all", 32'({FRAC_DECI_STATUS, IIR_24_STATUS, IIR_5_1_STATUS,
                                 IIR_5_2_STATUS, CIC_STATUS, FIR_STATUS}), 32'hFFF);
        rd(5'd8, 7'd90);
        check("rd90", MRDATA, 32'd1);
        xfer(1'b1, 5'd1, 7'd104, 20'd0);
        finish_xfer();
        check("fir_badsel", 32'(FIR_STATUS), 32'd3);
        xfer(1'b1, 5'd16, 7'd104, 20'd0);
        finish_xfer();
        check("fir_clr_ovf", 32'(FIR_STATUS), 32'd2);
        rd(5'd16, 7'd105);
        check("rd105", MRDATA, 32'd1);

        // Reset during SETUP of a write
        MTRANS = 1'b1; MWRITE = 1'b1; MSELx = 5'd1; MADDR = 7'd5; MWDATA = 20'd99;
        @(posedge clk); #1;
        MTRANS = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_mid_state", 32'(dut.state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_fd5", 32'(FRAC_DECI_OUT[5]), 32'd0);
        check("rst_mid_ctrl", 32'(CTRL_OUT), 32'd0);
        xfer(1'b1, 5'd1, 7'd5, 20'd9);
        finish_xfer();
        check("post_rst_wr5", 32'(FRAC_DECI_OUT[5]), 32'd9);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
